imem_ahb_responder: RTL
=======================

# imem_ahb_responder

Instruction-side AHB-lite responder that sits at the far end of the fetch interface driven by the PC/fetch stage. It accepts fetch addresses, returns 32-bit instruction words from an internal word-organised memory after a configurable number of wait states, and signals error responses for misaligned or out-of-range fetches. A loader write port fills the memory before or during operation.

## Interface
- `ADDR_WIDTH`, default 10: word-index bits; depth = 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `WAIT_STATES`, default 1: data-phase wait cycles per OK transfer, legal range 0..15.

- `clk_in`  in  1: single clock, rising edge.
- `rst_in`  in  1: reset, asynchronous and active-high.
- `trans_valid_in`  in  1: address-phase request; sampled only when `ahb_ready_out`=1.
- `iaddr_in`  in  32: fetch byte address, sampled with `trans_valid_in`.
- `instr_out`  out  32: instruction word; valid when `ahb_ready_out`=1 and `ahb_resp_out`=0 in a data phase.
- `ahb_ready_out`  out  1: transfer complete / responder free; 1 when idle.
- `ahb_resp_out`  out  1: 0 = OKAY, 1 = ERROR.
- `ld_we_in`  in  1: loader write enable.
- `ld_addr_in`  in  ADDR_WIDTH: loader word index.
- `ld_data_in`  in  32: loader write data.

## Operation
- States: IDLE, WAIT, DONE, ERR1, ERR2.
- Capture: on a rising edge with `ahb_ready_out`=1 and `trans_valid_in`=1, latch `iaddr_in`. Captures are possible only in IDLE, DONE and ERR2.
- Error check on the captured address:
  - Misaligned: `iaddr_in[1:0]`≠0.
  - Out of range: `iaddr_in` < BASE_ADDR, or `iaddr_in` ≥ BASE_ADDR + 4·2^ADDR_WIDTH. Compute the offset in 33 bits so there is no wrap.
  - Any error -> ERR1.
- OK path:
  - WAIT_STATES=0 -> DONE.
  - Otherwise -> WAIT, with a 4-bit counter loaded to WAIT_STATES−1.
  - WAIT holds `ahb_ready_out`=0 and decrements the counter; at 0 -> DONE.
- DONE: `ahb_ready_out`=1, `ahb_resp_out`=0, `instr_out` = mem[(addr−BASE_ADDR)>>2].
  - The memory is read on the edge that enters DONE.
  - A new capture on DONE's closing edge starts the next transfer (pipelined).
  - No capture -> IDLE.
- Error path: two-cycle AHB error.
  - ERR1: `ahb_ready_out`=0, `ahb_resp_out`=1.
  - ERR2: `ahb_ready_out`=1, `ahb_resp_out`=1.
  - Wait states are not applied.
  - Capture is allowed in ERR2; no capture -> IDLE.
- IDLE: `ahb_ready_out`=1, `ahb_resp_out`=0.
- `instr_out` holds its last value outside DONE.
- Loader:
  - Writes on any edge with `ld_we_in`=1, independent of state.
  - Read-before-write: a write to the same word on the edge entering DONE is not visible in that DONE cycle.
- `trans_valid_in`=0 with `ahb_ready_out`=1 is an idle transfer and is ignored.

## Timing
- Reset values (asynchronous assertion): state IDLE, `ahb_ready_out`=1, `ahb_resp_out`=0, `instr_out`=32'h0, counter 0.
- Memory contents are not reset.
- Reset mid-transfer abandons the pending transfer. After deassertion the block is in IDLE and accepts a capture on the first edge.
- Latency: address sampled at edge N. DONE occupies cycle N+1+WAIT_STATES.
- Error: ERR1 in cycle N+1, ERR2 in cycle N+2.
- Throughput: with WAIT_STATES=0, one instruction per cycle back-to-back. Otherwise one per WAIT_STATES+1 cycles.
- `iaddr_in` and `trans_valid_in` are don't-care while `ahb_ready_out`=0. The initiator holds them, but the block does not sample them.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Load mem[0..3]=32'h11111111..32'h44444444, WAIT_STATES=0. Fetch 0x0,0x4,0x8,0xC back-to-back -> `ahb_ready_out` stays 1; `instr_out` returns 11111111, 22222222, 33333333, 44444444 in cycles N+1..N+4.
- WAIT_STATES=3, fetch 0x4 at edge N -> `ahb_ready_out`=0 in cycles N+1..N+3; `ahb_ready_out`=1 with 22222222 in N+4.
- Fetch 0x6 (misaligned) -> ERR1 (ready 0, resp 1), then ERR2 (ready 1, resp 1). A capture of 0x0 in ERR2 is followed by an OK response of 11111111.
- ADDR_WIDTH=10, BASE_ADDR=0x1000. Fetch 0x0FFC and 0x2000 -> both return the error response. Fetch 0x1FFC -> OK with mem[1023].
- WAIT_STATES=2. Assert `rst_in` during WAIT -> immediately `ahb_ready_out`=1, `ahb_resp_out`=0, `instr_out`=0. After release, a fetch of 0x0 completes normally.
- Loader writes mem[0]=32'hDEADBEEF on the same edge that enters DONE for fetch 0x0 -> old value returned. The next fetch of 0x0 returns DEADBEEF.

Source files
------------

// File: rtl/imem_ahb_responder_if.sv
// Fetch-side AHB-lite bus between the PC/fetch stage (master) and the
// instruction memory responder (slave).
//   trans_valid_in : address-phase request
//   iaddr_in       : fetch byte address
//   instr_out      : returned instruction word
//   ahb_ready_out  : transfer complete / responder free
//   ahb_resp_out   : 0 = OKAY, 1 = ERROR
interface imem_ahb_responder_if;
  logic        trans_valid_in;
  logic [31:0] iaddr_in;
  logic [31:0] instr_out;
  logic        ahb_ready_out;
  logic        ahb_resp_out;

  modport master (
    output trans_valid_in,
    output iaddr_in,
    input  instr_out,
    input  ahb_ready_out,
    input  ahb_resp_out
  );

  modport slave (
    input  trans_valid_in,
    input  iaddr_in,
    output instr_out,
    output ahb_ready_out,
    output ahb_resp_out
  );
endinterface

// File: rtl/imem_ahb_responder.sv
// Instruction-side AHB-lite responder with an internal word memory.
// Returns instruction words after WAIT_STATES wait cycles, a two-cycle
// ERROR response for misaligned or out-of-range fetches, and accepts
// loader writes at any time.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   bus            : fetch bus (slave side)
//   ld_we_in       : loader write enable
//   ld_addr_in     : loader word index
//   ld_data_in     : loader write data
module imem_ahb_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  imem_ahb_responder_if.slave   bus,
  input  logic                  ld_we_in,
  input  logic [ADDR_WIDTH-1:0] ld_addr_in,
  input  logic [31:0]           ld_data_in
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] idx, idx_n;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  ready_n, resp_n;
  logic [32:0]           offset;
  logic                  misaligned, out_of_range, capture;

  logic [31:0] mem [DEPTH];

  // Address decode; an address below BASE_ADDR borrows into bit 32,
  // which also makes the range compare fail.
  assign offset       = {1'b0, bus.iaddr_in} - {1'b0, BASE_ADDR};
  assign misaligned   = |bus.iaddr_in[1:0];
  assign out_of_range = (offset >= SPAN);
  assign capture      = bus.ahb_ready_out && bus.trans_valid_in;

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    rd_idx  = idx;
    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        state_n = S_IDLE;
        if (capture) begin
          idx_n = offset[ADDR_WIDTH+1:2];
          if (misaligned || out_of_range) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_n = S_DONE;
            rd_idx  = idx_n;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_ERR1:  state_n = S_ERR2;
      default: state_n = S_IDLE;
    endcase
    ready_n = !(state_n inside {S_WAIT, S_ERR1});
    resp_n  = (state_n inside {S_ERR1, S_ERR2});
  end

  // State and registered outputs; memory is read on the edge entering DONE
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= S_IDLE;
      cnt               <= 4'd0;
      idx               <= '0;
      bus.ahb_ready_out <= 1'b1;
      bus.ahb_resp_out  <= 1'b0;
      bus.instr_out     <= 32'h0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      idx               <= idx_n;
      bus.ahb_ready_out <= ready_n;
      bus.ahb_resp_out  <= resp_n;
      if (state_n == S_DONE) begin
        bus.instr_out <= mem[rd_idx];
      end
    end
  end

  // Loader port; non-blocking write gives read-before-write on a shared edge
  always_ff @(posedge clk_in) begin
    if (ld_we_in) begin
      mem[ld_addr_in] <= ld_data_in;
    end
  end

endmodule
